imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The parameter list SHALL be: DEPTH, default 1001, number of 32-bit instruction-memory words (addresses 0..DEPTH-1).
REQ-002 The ports SHALL be: clk  in  1  single clock, all state updates on its rising edge.
REQ-003 The ports SHALL include: rst  in  1  synchronous, active-high reset.
REQ-004 The ports SHALL include: start  in  1  begin a load, one-cycle pulse.
REQ-005 The ports SHALL include: len  in  10  number of words to load, sampled when start is accepted.
REQ-006 The ports SHALL include: byte_valid  in  1  sender has a byte on byte_data.
REQ-007 The ports SHALL include: byte_data  in  8  program byte, first byte of each word is MSB.
REQ-008 The ports SHALL include: byte_ready  out  1  loader accepts byte this cycle.
REQ-009 The ports SHALL include: mem_we  out  1  one-cycle instruction-memory write strobe.
REQ-010 The ports SHALL include: mem_addr  out  32  word address, not byte address.
REQ-011 The ports SHALL include: mem_wdata  out  32  assembled instruction word.
REQ-012 The ports SHALL include: cpu_hold  out  1  holds PC/CPU in reset while high.
REQ-013 The ports SHALL include: busy  out  1  load in progress.
REQ-014 The ports SHALL include: done  out  1  load finished, program valid.
REQ-015 The ports SHALL include: error  out  1  last start rejected (len > DEPTH).

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT, WRITE, DONE.
REQ-017 IDLE or DONE with start=1 and 1<=len<=DEPTH SHALL go to COLLECT, latch len, clear mem_addr to 0, clear byte count, clear done and error, set cpu_hold=1.
REQ-018 start with len=0 in IDLE/DONE SHALL go directly to DONE next cycle with no write.
REQ-019 start with len>DEPTH SHALL set error=1, perform no write, and leave state and cpu_hold unchanged.
REQ-020 start SHALL be ignored in COLLECT and WRITE.
REQ-021 byte_ready SHALL equal 1 only in COLLECT; a byte is accepted on an edge where byte_valid&&byte_ready.
REQ-022 Accepted bytes SHALL shift in MSB-first: word = {b0,b1,b2,b3}.
REQ-023 On the edge accepting the 4th byte, state SHALL become WRITE; mem_we=1, mem_wdata=word, mem_addr=current index for exactly that cycle.
REQ-024 On leaving WRITE, mem_addr SHALL increment by 1; if words written equals latched len, state SHALL become DONE, else COLLECT.
REQ-025 In DONE: done=1, cpu_hold=0, busy=0; held until rst or an accepted start.
REQ-026 busy SHALL be 1 exactly in COLLECT and WRITE.
REQ-027 byte_valid low mid-word SHALL stall with partial word retained; no timeout.
REQ-028 mem_we SHALL never assert outside WRITE; mem_addr SHALL never exceed latched len-1 while mem_we=1.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, cpu_hold=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, byte count=0, regardless of state.
REQ-030 rst mid-load SHALL abort the load; no further writes; partial word discarded.

Structure
REQ-031 A shared package SHALL hold the state enum, DEPTH default, BYTES_PER_WORD=4 and LEN_W=10.
REQ-032 Byte-to-word shifting and byte counting SHALL be a sub-module named word_assembler; the FSM, address counter and outputs stay in imem_loader.

Verification
REQ-033 Reset then start, len=2, bytes 8C,01,00,04,AC,02,00,08 back-to-back -> writes 8C010004@0 then AC020008@1, byte_ready low each WRITE cycle, done=1 and cpu_hold=0 the cycle after the 2nd write.
REQ-034 len=1 with byte_valid dropped for 5 cycles after byte 2 -> single write of correct word@0, no extra mem_we.
REQ-035 start with len=1002 -> error=1, no mem_we, state stays IDLE, cpu_hold=1; next start len=1 clears error.
REQ-036 rst asserted after 3 bytes of word 1 -> next cycle all outputs at reset values, no write ever issued.
REQ-037 start pulsed during COLLECT with len=5 -> ignored, original len honoured; len=0 start -> done=1 next cycle, no write.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned DEPTH_DEFAULT  = 1001;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_W          = 10;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StWrite   = 2'd2,
        StDone    = 2'd3
    } state_e;

endpackage

// File: rtl/word_assembler.sv
// Shifts accepted bytes MSB-first into a 32-bit word and counts bytes within the word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_last
);

    localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

    logic [CntW-1:0] r_count;
    logic [31:0]     r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_word  <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_accept) begin
            r_word  <= {r_word[23:0], i_byte};
            // Wraps to zero after the final byte of each word.
            r_count <= r_count + CntW'(1);
        end
    end

    assign o_word = r_word;
    assign o_last = (r_count == CntW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory as 32-bit words and holds the CPU until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    state_e           r_state;
    state_e           w_state_next;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_addr;
    logic             r_error;

    logic        w_start_ok;
    logic        w_len_zero;
    logic        w_len_too_big;
    logic        w_load;
    logic        w_accept;
    logic        w_last_byte;
    logic        w_last_word;
    logic [31:0] w_word;

    assign w_start_ok    = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_len_zero    = (len == '0);
    assign w_len_too_big = (32'(len) > DEPTH);
    assign w_load        = w_start_ok && !w_len_zero && !w_len_too_big;
    assign w_accept      = byte_valid && (r_state == StCollect);
    assign w_last_word   = ((r_addr + 32'd1) == 32'(r_len));

    word_assembler u_word_assembler (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_load),
        .i_accept (w_accept),
        .i_byte   (byte_data),
        .o_word   (w_word),
        .o_last   (w_last_byte)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_start_ok && w_len_zero) begin
                    w_state_next = StDone;
                end else if (w_load) begin
                    w_state_next = StCollect;
                end
            end
            StCollect: begin
                if (w_accept && w_last_byte) begin
                    w_state_next = StWrite;
                end
            end
            StWrite: begin
                w_state_next = w_last_word ? StDone : StCollect;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_len   <= '0;
            r_addr  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                // An oversized request only flags; it must not disturb a finished program.
                if (w_len_too_big) begin
                    r_error <= 1'b1;
                end else begin
                    r_error <= 1'b0;
                    r_len   <= len;
                    r_addr  <= '0;
                end
            end else if (r_state == StWrite) begin
                r_addr <= r_addr + 32'd1;
            end
        end
    end

    assign byte_ready = (r_state == StCollect);
    assign mem_we     = (r_state == StWrite);
    assign mem_addr   = r_addr;
    assign mem_wdata  = w_word;
    assign cpu_hold   = (r_state != StDone);
    assign busy       = (r_state == StCollect) || (r_state == StWrite);
    assign done       = (r_state == StDone);
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued, a negedge monitor checks them.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    imem_loader #(.DEPTH(1001)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write at %0t",
                         mem_addr, mem_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
                check("ready_low_in_write", 32'(byte_ready), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    endtask

    task automatic pulse_start(input logic [9:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Leaves byte_valid high so consecutive calls stream back-to-back.
    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !got; i++) begin
            if (byte_ready) got = 1;
            tick();
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL byte_accept_timeout: got no byte_ready expected byte_ready=1 for %h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done; i++) tick();
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        len        = '0;
        byte_valid = 1'b0;
        byte_data  = '0;

        // Reset state
        do_reset();
        check_reset_outputs("rst0");

        // Two-word load, bytes back-to-back
        exp_q.push_back('{addr: 32'd0, data: 32'h8C01_0004});
        exp_q.push_back('{addr: 32'd1, data: 32'hAC02_0008});
        pulse_start(10'd2);
        check("l2_busy", 32'(busy), 32'd1);
        check("l2_ready", 32'(byte_ready), 32'd1);
        send_word(32'h8C01_0004);
        send_word(32'hAC02_0008);
        byte_valid = 1'b0;
        check("l2_we_last", 32'(mem_we), 32'd1);
        tick();
        check("l2_done", 32'(done), 32'd1);
        check("l2_cpu_hold", 32'(cpu_hold), 32'd0);
        check("l2_busy_after", 32'(busy), 32'd0);
        check("l2_drained", 32'(exp_q.size()), 32'd0);

        // Stall mid-word for 5 cycles
        exp_q.push_back('{addr: 32'd0, data: 32'h1234_5678});
        pulse_start(10'd1);
        check("stall_done_cleared", 32'(done), 32'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        byte_valid = 1'b0;
        repeat (5) tick();
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_ready", 32'(byte_ready), 32'd1);
        send_byte(8'h56);
        send_byte(8'h78);
        byte_valid = 1'b0;
        wait_done("stall");
        repeat (3) tick();
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Oversized length is rejected; state and hold untouched
        do_reset();
        pulse_start(10'd1002);
        check("big_error", 32'(error), 32'd1);
        check("big_busy", 32'(busy), 32'd0);
        check("big_hold", 32'(cpu_hold), 32'd1);
        check("big_done", 32'(done), 32'd0);
        tick();
        check("big_idle_ready", 32'(byte_ready), 32'd0);
        exp_q.push_back('{addr: 32'd0, data: 32'hDEAD_BEEF});
        pulse_start(10'd1);
        check("big_err_cleared", 32'(error), 32'd0);
        check("big_then_busy", 32'(busy), 32'd1);
        send_word(32'hDEAD_BEEF);
        byte_valid = 1'b0;
        wait_done("big");

        // len equal to DEPTH is legal
        do_reset();
        pulse_start(10'd1001);
        check("depth_error", 32'(error), 32'd0);
        check("depth_busy", 32'(busy), 32'd1);

        // Abort after 3 bytes: no write, partial word discarded
        do_reset();
        pulse_start(10'd2);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        do_reset();
        check_reset_outputs("abort");
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (4) tick();
        byte_valid = 1'b0;
        check("abort_idle_busy", 32'(busy), 32'd0);
        exp_q.push_back('{addr: 32'd0, data: 32'h0A0B_0C0D});
        pulse_start(10'd1);
        send_word(32'h0A0B_0C0D);
        byte_valid = 1'b0;
        wait_done("abort_reload");

        // start during COLLECT is ignored
        do_reset();
        exp_q.push_back('{addr: 32'd0, data: 32'h1122_3344});
        pulse_start(10'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        byte_valid = 1'b0;
        pulse_start(10'd5);
        check("ign_busy", 32'(busy), 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        byte_valid = 1'b0;
        wait_done("ign");
        repeat (5) tick();
        check("ign_still_done", 32'(done), 32'd1);
        check("ign_addr", mem_addr, 32'd1);

        // len=0 from DONE and from IDLE
        pulse_start(10'd0);
        check("zero_from_done", 32'(done), 32'd1);
        do_reset();
        pulse_start(10'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_hold", 32'(cpu_hold), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
